// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with producer scoreboard.
// Holds the clear-sequencer state encoding and the default geometry.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;

    // Clear sequencer: IDLE serves traffic, CLEAR walks the file, DONE pulses completion.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: word select, same-cycle writeback bypass and
// register-0 masking.
// Ports:
//   addr     - register index for this port
//   words    - full register array contents
//   busy_vec - scoreboard busy bits, one per register
//   byp_en   - a writeback is committing this cycle (already R0-filtered)
//   wr_addr  - writeback index
//   wr_data  - writeback data
//   data     - read data (combinational)
//   busy     - addressed register has an outstanding producer (combinational)
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   words,
    input  logic [(2**ADDR_W)-1:0]               busy_vec,
    input  logic                                 byp_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    output logic [DATA_W-1:0]                    data,
    output logic                                 busy
);

    logic is_zero;
    logic hit;

    assign is_zero = ZERO_R0 && (addr == '0);
    assign hit     = byp_en && (addr == wr_addr);

    // R0 mask beats bypass beats stored value; a bypassed read sees the
    // producer's result, so it is no longer busy.
    always_comb begin
        data = words[addr];
        busy = busy_vec[addr];
        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end else if (hit) begin
            data = wr_data;
            busy = 1'b0;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with a per-register busy scoreboard and a
// sequential whole-file clear.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   rd_addr/rd_data   - NUM_RD packed read ports (combinational, with bypass)
//   rd_busy           - per-port busy flag of the addressed register
//   wr_en/wr_addr/wr_data - writeback; clears the busy bit
//   alloc_en/alloc_addr   - producer issue; sets the busy bit (wins over writeback)
//   clr_req           - start a clear of every register and busy bit
//   clr_busy          - clear in progress (CLEAR and DONE)
//   clr_done          - one-cycle completion pulse (DONE)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_RD  = 2,
    parameter bit          ZERO_R0 = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       alloc_en,
    input  logic [ADDR_W-1:0]          alloc_addr,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    clr_state_t                    state;
    logic [ADDR_W-1:0]             clr_cnt;
    logic [DEPTH-1:0][DATA_W-1:0]  mem;
    logic [DEPTH-1:0]              busy;
    logic [DEPTH-1:0]              busy_next;
    logic                          idle;
    logic                          wr_ok;
    logic                          alloc_ok;
    logic                          clr_last;

    // Traffic is only accepted in IDLE; R0 is never a target when hardwired.
    assign idle     = (state == ST_IDLE);
    assign wr_ok    = idle && wr_en && !(ZERO_R0 && (wr_addr == '0));
    assign alloc_ok = idle && alloc_en && !(ZERO_R0 && (alloc_addr == '0));
    assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

    // Scoreboard update; alloc is applied last so it wins on a shared index.
    always_comb begin
        busy_next = busy;
        if (wr_ok) begin
            busy_next[wr_addr] = 1'b0;
        end
        if (alloc_ok) begin
            busy_next[alloc_addr] = 1'b1;
        end
    end

    // Clear sequencer, storage and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            mem      <= '0;
            busy     <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (wr_ok) begin
                        mem[wr_addr] <= wr_data;
                    end
                    busy <= busy_next;
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    mem[clr_cnt]  <= '0;
                    busy[clr_cnt] <= 1'b0;
                    if (clr_last) begin
                        clr_cnt  <= '0;
                        state    <= ST_DONE;
                        clr_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_cnt  <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Independent read ports.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_R0 (ZERO_R0)
        ) u_rd (
            .addr     (rd_addr[i*ADDR_W +: ADDR_W]),
            .words    (mem),
            .busy_vec (busy),
            .byp_en   (wr_ok),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .data     (rd_data[i*DATA_W +: DATA_W]),
            .busy     (rd_busy[i])
        );
    end

endmodule : regfile_scoreboard

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with hand-computed expectations.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        alloc_en;
    logic [3:0]  alloc_addr;
    logic        clr_req;
    logic        clr_busy;
    logic        clr_done;

    int n_chk  = 0;
    int n_pass = 0;

    regfile_scoreboard #(
        .DATA_W  (16),
        .ADDR_W  (4),
        .NUM_RD  (2),
        .ZERO_R0 (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        alloc_en = 1'b0;
        clr_req  = 1'b0;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
        idle_inputs();
        tick(); tick();
        rst = 1'b0;

        // Post-reset state
        set_rd(4'd3, 4'd9); #1;
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_busy", 32'(rd_busy), 32'h0);
        chk("rst_clr_busy", 32'(clr_busy), 32'h0);
        chk("rst_clr_done", 32'(clr_done), 32'h0);

        // Write R3, read on both ports next cycle
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        set_rd(4'd3, 4'd3); #1;
        chk("r3_both", rd_data, 32'hBEEF_BEEF);
        chk("r3_busy", 32'(rd_busy), 32'h0);

        // Same-cycle bypass on port 0, port 1 reads stored R3
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h1234;
        set_rd(4'd5, 4'd3); #1;
        chk("bypass", rd_data, 32'hBEEF_1234);
        tick();
        wr_en = 1'b0; #1;
        chk("r5_stored", rd_data, 32'hBEEF_1234);

        // Scoreboard: alloc, writeback, alloc+writeback together
        alloc_en = 1'b1; alloc_addr = 4'd7;
        tick();
        alloc_en = 1'b0;
        set_rd(4'd7, 4'd5); #1;
        chk("r7_busy", 32'(rd_busy), 32'h1);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h0042; #1;
        chk("r7_wr_busy_drop", 32'(rd_busy), 32'h0);
        chk("r7_wr_bypass", rd_data, 32'h1234_0042);
        tick();
        wr_en = 1'b0; #1;
        chk("r7_after_wr", 32'(rd_busy), 32'h0);
        wr_en = 1'b1; wr_data = 16'h0099; alloc_en = 1'b1; alloc_addr = 4'd7; #1;
        chk("r7_both_bypass_busy", 32'(rd_busy), 32'h0);
        tick();
        idle_inputs(); #1;
        chk("r7_alloc_wins", 32'(rd_busy), 32'h1);
        chk("r7_data_written", rd_data, 32'h1234_0099);

        // R0 is hardwired
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; alloc_en = 1'b1; alloc_addr = 4'd0;
        set_rd(4'd0, 4'd0); #1;
        chk("r0_no_bypass", rd_data, 32'h0);
        tick();
        idle_inputs(); #1;
        chk("r0_data", rd_data, 32'h0);
        chk("r0_busy", 32'(rd_busy), 32'h0);

        // Fill R1..R15, mark R9 busy as well
        for (int i = 1; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 16'h1000 + 16'(i);
            tick();
        end
        wr_en = 1'b0;
        alloc_en = 1'b1; alloc_addr = 4'd9;
        tick();
        alloc_en = 1'b0;
        set_rd(4'd15, 4'd9); #1;
        chk("fill_r15_r9", rd_data, 32'h1009_100F);
        chk("fill_busy", 32'(rd_busy), 32'h2);

        // Clear: 16 CLEAR cycles plus one DONE cycle; traffic ignored throughout
        clr_req = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 4'd4; wr_data = 16'hAAAA;
        alloc_en = 1'b1; alloc_addr = 4'd10;
        set_rd(4'd4, 4'd9);
        for (int k = 1; k <= 17; k++) begin
            #1;
            chk($sformatf("clr_busy_c%0d", k), 32'(clr_busy), 32'h1);
            chk($sformatf("clr_done_c%0d", k), 32'(clr_done), (k == 17) ? 32'h1 : 32'h0);
            if (k == 1) begin
                chk("clr_no_bypass", rd_data, 32'h1009_1004);
            end
            tick();
        end
        idle_inputs(); #1;
        chk("clr_end_busy", 32'(clr_busy), 32'h0);
        chk("clr_end_done", 32'(clr_done), 32'h0);
        for (int i = 0; i < 16; i++) begin
            set_rd(4'(i), 4'(15 - i)); #1;
            chk($sformatf("clr_zero_r%0d", i), rd_data, 32'h0);
            chk($sformatf("clr_nbusy_r%0d", i), 32'(rd_busy), 32'h0);
        end

        // Reset in the 5th CLEAR cycle aborts the clear
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h5555;
        tick();
        wr_addr = 4'd12; wr_data = 16'h6666;
        tick();
        wr_en = 1'b0;
        alloc_en = 1'b1; alloc_addr = 4'd12;
        tick();
        alloc_en = 1'b0;
        set_rd(4'd2, 4'd12); #1;
        chk("pre_abort", rd_data, 32'h6666_5555);
        chk("pre_abort_busy", 32'(rd_busy), 32'h2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick(); tick();
        chk("abort_in_clear", 32'(clr_busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("abort_clr_busy", 32'(clr_busy), 32'h0);
        chk("abort_regs", rd_data, 32'h0);
        chk("abort_busy", 32'(rd_busy), 32'h0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (clr_done) pulses++;
            tick();
        end
        chk("abort_no_done", 32'(pulses), 32'h0);

        // Back in IDLE: writes accepted again
        wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0A0A;
        tick();
        wr_en = 1'b0; #1;
        chk("post_abort_wr", rd_data, 32'h0000_0A0A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_regfile_scoreboard

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register index width; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_R0, default 1, meaning register 0 reads as zero, is never written and is never busy.
REQ-005 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port rd_addr  input  NUM_RD*ADDR_W  packed read indices, port i at bits [i*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  output  NUM_RD*DATA_W  packed read data, port i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port rd_busy  output  NUM_RD  per-port flag: the addressed register has an outstanding producer.
REQ-010 SHALL have port wr_en  input  1  writeback strobe.
REQ-011 SHALL have ports wr_addr  input  ADDR_W and wr_data  input  DATA_W: writeback index and data.
REQ-012 SHALL have ports alloc_en  input  1 and alloc_addr  input  ADDR_W: producer issue, marks the destination busy.
REQ-013 SHALL have port clr_req  input  1  request to zero the whole file.
REQ-014 SHALL have ports clr_busy  output  1 (clear in progress) and clr_done  output  1 (one-cycle completion pulse).

Function
REQ-015 Reads SHALL be combinational; rd_data[i] = stored value of rd_addr[i].
REQ-016 Writes SHALL commit at the rising clk edge when wr_en=1 and the FSM is in IDLE.
REQ-017 Bypass: if wr_en=1, FSM in IDLE and wr_addr==rd_addr[i] (nonzero when ZERO_R0=1), rd_data[i] SHALL equal wr_data in that same cycle.
REQ-018 Scoreboard: a DEPTH-bit busy vector SHALL be held; alloc_en sets busy[alloc_addr] and wr_en clears busy[wr_addr] at the next edge.
REQ-019 When alloc and write target the same index in one cycle, alloc SHALL win (busy ends at 1; data is still written).
REQ-020 rd_busy[i] SHALL equal busy[rd_addr[i]], forced to 0 when the REQ-017 bypass is active for port i.
REQ-021 With ZERO_R0=1, reads of index 0 SHALL return 0 and rd_busy 0; writes and allocs to index 0 SHALL be ignored.
REQ-022 FSM states SHALL be IDLE, CLEAR and DONE.
REQ-023 IDLE->CLEAR on clr_req=1; CLEAR holds a counter starting at 0, zeroes the data and busy bit at index counter each cycle, and increments.
REQ-024 CLEAR->DONE after the cycle that clears index DEPTH-1 (exactly DEPTH cycles in CLEAR); DONE->IDLE unconditionally after one cycle.
REQ-025 clr_busy SHALL be 1 in CLEAR and DONE; clr_done SHALL be 1 only in DONE.
REQ-026 In CLEAR and DONE, wr_en, alloc_en and clr_req SHALL be ignored and bypass disabled; reads SHALL return stored values.
REQ-027 The counter SHALL be ADDR_W bits wide and SHALL wrap to 0 on leaving CLEAR.

Reset
REQ-028 On a clk edge with rst=1, all registers SHALL be 0, busy all 0, FSM IDLE and counter 0; rst overrides every other input.
REQ-029 Reset asserted during CLEAR SHALL abort the clear; no clr_done pulse SHALL follow.
REQ-030 Outputs after reset: rd_data 0 for all ports, rd_busy 0, clr_busy 0, clr_done 0.

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state enum and the default values of DATA_W and ADDR_W.
REQ-032 One sub-module, regfile_read_port, SHALL implement per-port select, bypass and R0 masking, instantiated NUM_RD times in a generate loop.

Verification
REQ-033 Reset, write R3=0xBEEF, then read R3 on both ports next cycle -> 0xBEEF on both, rd_busy=00.
REQ-034 wr_en=1, wr_addr=5, wr_data=0x1234 and rd_addr[0]=5 in the same cycle -> rd_data[0]=0x1234 that cycle.
REQ-035 alloc R7; next cycle read R7 -> rd_busy=1; wr R7=0x0042 -> rd_busy drops in the write cycle; alloc+wr R7 together -> busy remains 1.
REQ-036 ZERO_R0=1: write R0=0xFFFF, alloc R0 -> R0 reads 0x0000, rd_busy 0.
REQ-037 Fill R1..R15, pulse clr_req -> clr_busy high 17 cycles, clr_done only in the 17th; writes during clear dropped; all reads 0 afterwards.
REQ-038 Assert rst at the 5th CLEAR cycle -> IDLE next cycle, clr_done never pulses, all registers 0.
